// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage owning the data memory; runs multi-cycle loads/stores,
// stalls upstream while busy and flags misaligned accesses with a one-cycle pulse.
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeBackIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [4:0]  destRegIn,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] writeDataIn,
    output logic        writeBackOut,
    output logic        memReadOut,
    output logic [4:0]  destRegOut,
    output logic [31:0] ALUResOut,
    output logic [31:0] memDataOut,
    output logic        stall,
    output logic        addrErr
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        mem [DEPTH];
    logic               req, mis, done, pass;
    always_comb begin
        req     = memReadIn | memWriteIn;
        mis     = req & (ALUResIn[1:0] != 2'b00);
        done    = (state_q == BUSY) && (cnt_q == '0);
        // outputs only reflect inputs when nothing is pending; rst gating keeps them 0 in reset
        pass    = rst & (((state_q == IDLE) & ~req) | done);
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && req && !mis) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MEM_LAT - 1);
            addr_d  = ALUResIn[ADDR_W+1:2];
            wdata_d = writeDataIn;
        end else if (state_q == BUSY) begin
            state_d = done ? IDLE : BUSY;
            cnt_d   = done ? cnt_q : cnt_q - 1'b1;
        end
        writeBackOut = pass & writeBackIn;
        memReadOut   = pass & memReadIn;
        destRegOut   = rst ? destRegIn : 5'd0;
        ALUResOut    = rst ? ALUResIn : 32'd0;
        memDataOut   = (rst & done & memReadIn) ? mem[addr_q] : 32'd0;
        stall        = rst & ((((state_q == IDLE) & req & ~mis)) | ((state_q == BUSY) & ~done));
        addrErr      = rst & (state_q == IDLE) & mis;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    // array is deliberately unreset; an aborted access never reaches done, so it never writes
    always_ff @(posedge clk) begin
        if (done && memWriteIn) mem[addr_q] <= wdata_q;
    end
endmodule
